aes128_word_if: RTL and testbench

AES128_WORD_IF -- requirements
Module: aes128_word_if

---
 rtl/aes128_pkg.sv | 19 +
 rtl/aes128_word_if_if.sv | 34 +++
 rtl/aes128_word_shreg.sv | 29 ++
 rtl/aes128_word_if.sv | 122 ++++++++++++
 tb/tb_aes128_word_if.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes128_pkg.sv
// Shared definitions for the word-serial AES-128 host interface.
//   aes_if_state_t : sequencing state of aes128_word_if
//   AES_BLK_W      : AES block / key width in bits
//   AES_WORD_W     : host bus word width in bits
//   AES_WORDS      : words per block
package aes128_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_WORD_W = 32;
  localparam int AES_WORDS  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } aes_if_state_t;

endpackage

// File: rtl/aes128_word_if_if.sv
// Host-side bus of aes128_word_if: word writes, commands and result reads.
//   wr_*  : key/text word writes into the block
//   cmd_* : encrypt/decrypt command
//   rd_*  : result words out of the block
// Handshake rule for all three channels: a transfer happens on the rising
// clock edge where valid and ready are both 1. The source holds valid and its
// payload stable until that edge; ready may rise and fall freely.
// modport master = host side, modport slave = aes128_word_if side.
interface aes128_word_if_if;
  import aes128_pkg::*;

  logic                  wr_valid_i;
  logic                  wr_ready_o;
  logic                  wr_key_i;
  logic [AES_WORD_W-1:0] wr_data_i;
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_dec_i;
  logic                  rd_valid_o;
  logic                  rd_ready_i;
  logic [AES_WORD_W-1:0] rd_data_o;
  logic                  rd_last_o;

  modport master (
    output wr_valid_i, wr_key_i, wr_data_i, cmd_valid_i, cmd_dec_i, rd_ready_i,
    input  wr_ready_o, cmd_ready_o, rd_valid_o, rd_data_o, rd_last_o
  );

  modport slave (
    input  wr_valid_i, wr_key_i, wr_data_i, cmd_valid_i, cmd_dec_i, rd_ready_i,
    output wr_ready_o, cmd_ready_o, rd_valid_o, rd_data_o, rd_last_o
  );

endinterface

// File: rtl/aes128_word_shreg.sv
// 128-bit word-serial register.
//   shift_en : shift left by one word, word_i enters at [31:0]
//   load_en  : parallel load of par_i (wins over shift_en)
//   q_o      : full register; the oldest word sits at [127:96]
// Four shifts leave the first word in [127:96] (big-endian order), and
// reading [127:96] while shifting emits the words in that same order.
module aes128_word_shreg
  import aes128_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic [AES_WORD_W-1:0] word_i,
  input  logic                  load_en,
  input  logic [AES_BLK_W-1:0]  par_i,
  output logic [AES_BLK_W-1:0]  q_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_o <= '0;
    end else if (load_en) begin
      q_o <= par_i;
    end else if (shift_en) begin
      q_o <= {q_o[AES_BLK_W-AES_WORD_W-1:0], word_i};
    end
  end

endmodule

// File: rtl/aes128_word_if.sv
// Word-serial host interface in front of an AES-128 core.
//   clk, rst            : clock, asynchronous active-high reset
//   bus                 : host write/command/read channels (slave side)
//   core_start_enc_o/_dec_o : one-cycle start pulses to the core
//   core_key_o/text_o   : key and text blocks presented to the core
//   core_text_i         : core result, captured on core_done_i in WAIT
//   core_ready_i        : core idle flag, gates command acceptance
//   core_done_i         : core completion pulse
//   busy_o              : high whenever the sequencer is not IDLE
//   state_o             : current sequencer state (debug visibility)
// KEY_RETAIN=1 keeps the key valid across operations; 0 drops it when the
// last result word has been read.
module aes128_word_if
  import aes128_pkg::*;
#(
  parameter bit KEY_RETAIN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  aes128_word_if_if.slave      bus,
  output logic                 core_start_enc_o,
  output logic                 core_start_dec_o,
  output logic [AES_BLK_W-1:0] core_key_o,
  output logic [AES_BLK_W-1:0] core_text_o,
  input  logic [AES_BLK_W-1:0] core_text_i,
  input  logic                 core_ready_i,
  input  logic                 core_done_i,
  output logic                 busy_o,
  output aes_if_state_t        state_o
);

  aes_if_state_t state_q, state_d;
  logic [1:0]    key_cnt_q, text_cnt_q, rd_cnt_q;
  logic          key_valid_q, text_valid_q, dec_q;
  logic          cmd_fire, wr_fire, key_wr, text_wr, rd_fire;
  logic          done_cap, drain_done;
  logic [AES_BLK_W-1:0] res_q;

  // A command beats a write offered in the same cycle.
  assign bus.cmd_ready_o = (state_q == IDLE) && key_valid_q && text_valid_q && core_ready_i;
  assign cmd_fire        = bus.cmd_valid_i && bus.cmd_ready_o;
  assign bus.wr_ready_o  = !rst && (state_q == IDLE) && !cmd_fire;
  assign wr_fire         = bus.wr_valid_i && bus.wr_ready_o;
  assign key_wr          = wr_fire && bus.wr_key_i;
  assign text_wr         = wr_fire && !bus.wr_key_i;

  assign bus.rd_valid_o  = (state_q == DRAIN);
  assign bus.rd_data_o   = res_q[AES_BLK_W-1 -: AES_WORD_W];
  assign bus.rd_last_o   = (state_q == DRAIN) && (rd_cnt_q == 2'd3);
  assign rd_fire         = bus.rd_valid_o && bus.rd_ready_i;

  // core_done_i is only meaningful while waiting on the core.
  assign done_cap        = (state_q == WAIT) && core_done_i;
  assign drain_done      = rd_fire && (rd_cnt_q == 2'd3);

  assign core_start_enc_o = (state_q == START) && !dec_q;
  assign core_start_dec_o = (state_q == START) && dec_q;
  assign busy_o           = (state_q != IDLE);
  assign state_o          = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire)   state_d = START;
      START:                   state_d = WAIT;
      WAIT:    if (core_done_i) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Word counters and block valid flags. Writes are only accepted in IDLE,
  // so they never coincide with the end of DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_cnt_q    <= '0;
      text_cnt_q   <= '0;
      rd_cnt_q     <= '0;
      key_valid_q  <= 1'b0;
      text_valid_q <= 1'b0;
      dec_q        <= 1'b0;
    end else begin
      if (key_wr) begin
        key_cnt_q <= key_cnt_q + 2'd1;
        if (key_cnt_q == 2'd0) key_valid_q <= 1'b0;
        if (key_cnt_q == 2'd3) key_valid_q <= 1'b1;
      end
      if (text_wr) begin
        text_cnt_q <= text_cnt_q + 2'd1;
        if (text_cnt_q == 2'd0) text_valid_q <= 1'b0;
        if (text_cnt_q == 2'd3) text_valid_q <= 1'b1;
      end
      if (cmd_fire) dec_q <= bus.cmd_dec_i;
      if (rd_fire)  rd_cnt_q <= rd_cnt_q + 2'd1;
      if (drain_done) begin
        text_valid_q <= 1'b0;
        if (!KEY_RETAIN) key_valid_q <= 1'b0;
      end
    end
  end

  aes128_word_shreg u_key (
    .clk(clk), .rst(rst), .shift_en(key_wr), .word_i(bus.wr_data_i),
    .load_en(1'b0), .par_i('0), .q_o(core_key_o)
  );

  aes128_word_shreg u_text (
    .clk(clk), .rst(rst), .shift_en(text_wr), .word_i(bus.wr_data_i),
    .load_en(1'b0), .par_i('0), .q_o(core_text_o)
  );

  aes128_word_shreg u_res (
    .clk(clk), .rst(rst), .shift_en(rd_fire), .word_i('0),
    .load_en(done_cap), .par_i(core_text_i), .q_o(res_q)
  );

endmodule

// File: tb/tb_aes128_word_if.sv
module tb_aes128_word_if;
  import aes128_pkg::*;

  localparam logic [127:0] K0  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] PT0 = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] CT0 = 128'h3925841d_02dc09fb_dc118597_196a0b32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 core_start_enc_o, core_start_dec_o;
  logic [AES_BLK_W-1:0] core_key_o, core_text_o, core_text_i;
  logic                 core_ready_i, core_done_i, busy_o;
  aes_if_state_t        state_o;

  aes128_word_if_if bus ();

  aes128_word_if #(.KEY_RETAIN(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .core_start_enc_o(core_start_enc_o), .core_start_dec_o(core_start_dec_o),
    .core_key_o(core_key_o), .core_text_o(core_text_o), .core_text_i(core_text_i),
    .core_ready_i(core_ready_i), .core_done_i(core_done_i),
    .busy_o(busy_o), .state_o(state_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  // ---------------- core model ----------------
  int           enc_cnt = 0, dec_cnt = 0, lat = 0;
  bit           core_hold = 0, core_ready_en = 1, stray_done_req = 0, pending = 0;
  logic [127:0] cap_res;

  function automatic logic [127:0] core_fn(input bit dec, input logic [127:0] k, input logic [127:0] t);
    if (k == K0 && !dec && t == PT0) return CT0;
    if (k == K0 && dec && t == CT0) return PT0;
    if (dec) return t ^ k ^ 128'h0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f0f;
    return {t[95:0], t[127:96]} ^ k;
  endfunction

  initial begin
    core_done_i = 1'b0;
    core_text_i = '0;
    core_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      core_done_i = 1'b0;
      if (rst) begin
        pending = 0;
      end else if (core_start_enc_o || core_start_dec_o) begin
        if (core_start_enc_o) enc_cnt++;
        if (core_start_dec_o) dec_cnt++;
        cap_res = core_fn(core_start_dec_o, core_key_o, core_text_o);
        pending = 1;
        lat = $urandom_range(1, 4);
      end else if (pending && !core_hold) begin
        if (lat > 0) lat--;
        else begin
          core_done_i = 1'b1;
          core_text_i = cap_res;
          pending = 0;
        end
      end else if (stray_done_req) begin
        core_done_i = 1'b1;
        core_text_i = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        stray_done_req = 0;
      end
      core_ready_i = core_ready_en && !pending;
    end
  end

  // ---------------- checking / drivers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_word(input bit is_key, input logic [31:0] data);
    int n = 0;
    bit ok = 0;
    @(negedge clk);
    bus.wr_valid_i = 1'b1;
    bus.wr_key_i   = is_key;
    bus.wr_data_i  = data;
    while (!ok && n < 50) begin
      #1;
      if (bus.wr_ready_o) ok = 1;
      else begin n++; @(negedge clk); end
    end
    if (!ok) check("wr_ready_timeout", 0, 1);
    else @(posedge clk);
    #1 bus.wr_valid_i = 1'b0;
  endtask

  task automatic write_block(input bit is_key, input logic [127:0] blk);
    for (int i = 0; i < 4; i++) write_word(is_key, blk[127-32*i -: 32]);
  endtask

  task automatic push_exp(input logic [127:0] blk);
    for (int i = 0; i < 4; i++) exp_q.push_back(blk[127-32*i -: 32]);
  endtask

  task automatic send_cmd(input bit dec, input bit push, input logic [127:0] exp);
    int n = 0;
    bit ok = 0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_dec_i   = dec;
    while (!ok && n < 50) begin
      #1;
      if (bus.cmd_ready_o) ok = 1;
      else begin n++; @(negedge clk); end
    end
    check("cmd_accept", ok, 1);
    if (ok) @(posedge clk);
    #1 bus.cmd_valid_i = 1'b0;
    if (ok && push) push_exp(exp);
  endtask

  task automatic offer_cmd_refused(input string name, input int cyc);
    int s0 = enc_cnt + dec_cnt;
    bit bad = 0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_dec_i   = 1'b0;
    repeat (cyc) begin
      #1 if (bus.cmd_ready_o) bad = 1;
      @(negedge clk);
    end
    bus.cmd_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check(name, bad, 0);
    check({name, "_no_start"}, enc_cnt + dec_cnt - s0, 0);
    check({name, "_idle"}, state_o, IDLE);
  endtask

  task automatic read_block(input bit stall);
    logic [31:0] held, exp;
    logic        held_last;
    bit          bad;
    int          n;
    for (int w = 0; w < 4; w++) begin
      n = 0;
      @(negedge clk);
      while (!bus.rd_valid_o && n < 200) begin @(negedge clk); n++; end
      if (!bus.rd_valid_o) begin
        check("rd_valid_timeout", 0, 1);
        return;
      end
      if (stall) begin
        held = bus.rd_data_o;
        held_last = bus.rd_last_o;
        bad = 0;
        repeat (5) begin
          @(negedge clk);
          if (bus.rd_data_o !== held || bus.rd_last_o !== held_last ||
              !bus.rd_valid_o || !busy_o) bad = 1;
        end
        check("rd_stall_stable", bad, 0);
      end
      bus.rd_ready_i = 1'b1;
      #1;
      if (exp_q.size() == 0) begin
        check("rd_unexpected_word", 1, 0);
        exp = '0;
      end else exp = exp_q.pop_front();
      check($sformatf("rd_data_w%0d", w), bus.rd_data_o, exp);
      check($sformatf("rd_last_w%0d", w), bus.rd_last_o, (w == 3));
      check($sformatf("busy_w%0d", w), busy_o, 1);
      @(posedge clk);
      #1 bus.rd_ready_i = 1'b0;
    end
    @(negedge clk);
    check("busy_after_drain", busy_o, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit           wr_key;
    logic [127:0] key;
    logic [127:0] text;
    bit           dec;
    bit           stall;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [127:0] k1, t2, t3, t4, t5;
    int e0, d0;
    bit bad;

    bus.wr_valid_i = 1'b0; bus.wr_key_i = 1'b0; bus.wr_data_i = '0;
    bus.cmd_valid_i = 1'b0; bus.cmd_dec_i = 1'b0; bus.rd_ready_i = 1'b0;

    k1 = {$urandom, $urandom, $urandom, $urandom};
    t2 = {$urandom, $urandom, $urandom, $urandom};
    t3 = {$urandom, $urandom, $urandom, $urandom};
    t4 = {$urandom, $urandom, $urandom, $urandom};
    t5 = {$urandom, $urandom, $urandom, $urandom};
    vecs[0] = '{1'b1, K0, PT0, 1'b0, 1'b0, CT0};
    vecs[1] = '{1'b0, K0, CT0, 1'b1, 1'b0, PT0};
    vecs[2] = '{1'b1, k1, t2,  1'b0, 1'b1, core_fn(1'b0, k1, t2)};
    vecs[3] = '{1'b0, k1, t3,  1'b1, 1'b0, core_fn(1'b1, k1, t3)};

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_state", state_o, IDLE);
    check("rst_ctrl", {busy_o, bus.wr_ready_o, bus.cmd_ready_o, bus.rd_valid_o,
                       bus.rd_last_o, core_start_enc_o, core_start_dec_o}, 0);
    check("rst_key", core_key_o, 0);
    check("rst_text", core_text_o, 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    check("no_start_after_reset", enc_cnt + dec_cnt, 0);
    check("wr_ready_idle", bus.wr_ready_o, 1);
    check("cmd_ready_no_blocks", bus.cmd_ready_o, 0);

    // table-driven operations
    for (int v = 0; v < 4; v++) begin
      e0 = enc_cnt;
      d0 = dec_cnt;
      if (vecs[v].wr_key) write_block(1'b1, vecs[v].key);
      write_block(1'b0, vecs[v].text);
      send_cmd(vecs[v].dec, 1'b1, vecs[v].exp);
      @(negedge clk);
      check($sformatf("v%0d_start_enc", v), core_start_enc_o, !vecs[v].dec);
      check($sformatf("v%0d_start_dec", v), core_start_dec_o, vecs[v].dec);
      check($sformatf("v%0d_core_key", v), core_key_o, vecs[v].key);
      check($sformatf("v%0d_core_text", v), core_text_o, vecs[v].text);
      read_block(vecs[v].stall);
      check($sformatf("v%0d_enc_pulses", v), enc_cnt - e0, vecs[v].dec ? 0 : 1);
      check($sformatf("v%0d_dec_pulses", v), dec_cnt - d0, vecs[v].dec ? 1 : 0);
    end

    // gating: partial text, then core not ready, then writes during WAIT
    for (int i = 0; i < 3; i++) write_word(1'b0, t4[127-32*i -: 32]);
    offer_cmd_refused("cmd_gate_partial", 4);
    write_word(1'b0, t4[31:0]);
    core_ready_en = 0;
    repeat (2) @(negedge clk);
    offer_cmd_refused("cmd_gate_core_busy", 4);
    core_ready_en = 1;
    core_hold = 1;
    send_cmd(1'b0, 1'b1, core_fn(1'b0, k1, t4));
    repeat (2) @(negedge clk);
    check("gate_state_wait", state_o, WAIT);
    check("gate_core_text", core_text_o, t4);
    bus.wr_valid_i = 1'b1;
    bus.wr_key_i   = 1'b0;
    bus.wr_data_i  = 32'h1234_5678;
    bad = 0;
    repeat (3) begin
      #1 if (bus.wr_ready_o) bad = 1;
      @(negedge clk);
    end
    bus.wr_valid_i = 1'b0;
    check("wr_ready_in_wait", bad, 0);
    check("gate_text_held", core_text_o, t4);
    core_hold = 0;
    read_block(1'b0);

    // simultaneous command and text write in IDLE
    write_block(1'b0, t3);
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_dec_i   = 1'b0;
    bus.wr_valid_i  = 1'b1;
    bus.wr_key_i    = 1'b0;
    bus.wr_data_i   = 32'hffff_ffff;
    #1;
    check("simul_cmd_ready", bus.cmd_ready_o, 1);
    check("simul_wr_ready", bus.wr_ready_o, 0);
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b0;
    bus.wr_valid_i  = 1'b0;
    push_exp(core_fn(1'b0, k1, t3));
    @(negedge clk);
    check("simul_text_unchanged", core_text_o, t3);
    read_block(1'b0);

    // reset while waiting on the core, then a stray completion pulse
    write_block(1'b0, t5);
    core_hold = 1;
    send_cmd(1'b0, 1'b0, '0);
    repeat (2) @(negedge clk);
    check("pre_reset_wait", state_o, WAIT);
    rst = 1'b1;
    #1;
    check("midrst_state", state_o, IDLE);
    check("midrst_ctrl", {busy_o, bus.wr_ready_o, bus.cmd_ready_o, bus.rd_valid_o,
                          bus.rd_last_o, core_start_enc_o, core_start_dec_o}, 0);
    check("midrst_rd_data", bus.rd_data_o, 0);
    check("midrst_key", core_key_o, 0);
    check("midrst_text", core_text_o, 0);
    @(negedge clk) rst = 1'b0;
    core_hold = 0;
    e0 = enc_cnt + dec_cnt;
    stray_done_req = 1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rd_valid_o || busy_o) bad = 1;
    end
    check("stray_done_ignored", bad, 0);
    check("stray_state_idle", state_o, IDLE);
    check("post_reset_no_start", enc_cnt + dec_cnt - e0, 0);

    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
